// File: rtl/ahb_uart_prog.sv
// ---------------------------------------------------------------------------
// ahb_uart_prog
//   AHB-Lite slave UART with a programmable baud divisor, TX/RX FIFOs of
//   2**FIFO_AW bytes, optional even/odd parity, sticky error flags and a
//   maskable level interrupt. Frames are 8N1 or 8P1, LSB first, 16x
//   oversampled.
//
//   Register map (HADDR[3:2]):
//     0x0 DATA    W: push TX byte (stalls while TX FIFO full)  R: pop RX byte
//     0x4 STATUS  R: {frame_err, parity_err, overrun, rx_full, tx_empty, rx_empty}
//                 W: 1 clears bits [5:3]
//     0x8 CTRL    [0]tx_en [1]rx_en [2]par_en [3]par_odd [4]ie_rx [5]ie_txe [6]ie_err
//     0xC BAUDDIV [15:0] tick period minus 1, picked up at the next reload
//
//   Ports:
//     HCLK, HRESETn        clock, asynchronous active-low reset
//     HSEL..HREADY         AHB-Lite slave inputs
//     HREADYOUT, HRDATA    AHB-Lite slave outputs
//     RsRx / RsTx          serial in (asynchronous) / serial out (idle high)
//     uart_irq             level interrupt
// ---------------------------------------------------------------------------

// Byte-wide synchronous FIFO used for both directions.
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data (ignored when full unless popping)
//   pop, rdata     read request (ignored when empty) and head-of-queue data
//   empty, full    occupancy flags
module ahb_uart_prog_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = count[AW];
  // A pop on an empty FIFO is dropped; a push on a full FIFO is accepted only
  // when a pop frees the head slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count and pointers
  // alone decide which entries are valid, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo depth.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

module ahb_uart_prog #(
  parameter int          FIFO_AW = 4,
  parameter logic [15:0] DIV_RST = 16'd162
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        RsRx,
  output logic        RsTx,
  output logic        uart_irq
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------- bus data-phase registers ----------------
  logic       dp_sel;
  logic       dp_write;
  logic [1:0] dp_addr;

  // ---------------- configuration and status ----------------
  logic [6:0]  ctrl;
  logic [15:0] baud_div;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic [5:0]  status;

  // ---------------- FIFO interfaces ----------------
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_rdata, rx_byte;

  // ---------------- decoded data-phase accesses ----------------
  logic wr_data, rd_data, wr_status, wr_ctrl, wr_baud;

  // ---------------- tick generator ----------------
  logic [15:0] tick_cnt;
  logic        tick;

  // ---------------- transmitter ----------------
  state_t     tx_state;
  logic [3:0] tx_tick;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic       tx_par;

  // ---------------- receiver ----------------
  state_t     rx_state;
  logic       rx_meta, rx_sync, rx_prev;
  logic [3:0] rx_tick;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_par_en;
  logic       rx_par_ok;

  // Address bits outside [3:2], HTRANS[0] and upper write data are not decoded.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

  // Address phase is captured only while the bus is ready, so a stalled data
  // phase keeps its decode until it completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_sel   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else if (HREADY) begin
      dp_sel   <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_data   = dp_sel &  dp_write & (dp_addr == 2'd0);
  assign rd_data   = dp_sel & ~dp_write & (dp_addr == 2'd0);
  assign wr_status = dp_sel &  dp_write & (dp_addr == 2'd1);
  assign wr_ctrl   = dp_sel &  dp_write & (dp_addr == 2'd2);
  assign wr_baud   = dp_sel &  dp_write & (dp_addr == 2'd3);

  // A DATA write waits for a free slot; the push lands in the first cycle
  // the TX FIFO is not full, which is also the cycle HREADYOUT returns high.
  assign HREADYOUT = ~(wr_data & tx_full);
  assign tx_push   = wr_data & ~tx_full;
  assign rx_pop    = rd_data & ~rx_empty;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl     <= 7'd0;
      baud_div <= DIV_RST;
    end else begin
      if (wr_ctrl) ctrl     <= HWDATA[6:0];
      if (wr_baud) baud_div <= HWDATA[15:0];
    end
  end

  assign status = {frame_err, parity_err, overrun, rx_full, tx_empty, rx_empty};

  // NOTE: combinational blocks assign a default first so no path can leave
  // the output unassigned and infer a latch.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_sel && !dp_write) begin
      case (dp_addr)
        2'd0:    HRDATA = rx_empty ? 32'd0 : {24'd0, rx_rdata};
        2'd1:    HRDATA = {26'd0, status};
        2'd2:    HRDATA = {25'd0, ctrl};
        default: HRDATA = {16'd0, baud_div};
      endcase
    end
  end

  // 16x oversample tick: one-cycle pulse every baud_div+1 cycles. A new
  // divisor only takes effect when the counter reloads.
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)  tick_cnt <= DIV_RST;
    else if (tick) tick_cnt <= baud_div;
    else           tick_cnt <= tick_cnt - 16'd1;
  end

  ahb_uart_prog_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (HWDATA[7:0]),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .full  (tx_full)
  );

  ahb_uart_prog_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_byte),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Frames start on a tick so every bit, including the start bit, is exactly
  // 16 ticks long.
  assign tx_pop = tick & (tx_state == ST_IDLE) & ctrl[0] & ~tx_empty;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_state <= ST_IDLE;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_par   <= 1'b0;
      RsTx     <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_state <= ST_START;
            tx_tick  <= 4'd0;
            tx_shift <= tx_rdata;
            // Odd parity is the inverted XOR of the data bits.
            tx_par   <= (^tx_rdata) ^ ctrl[3];
            RsTx     <= 1'b0;
          end
        end
        ST_START: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx_state <= ST_DATA;
            tx_bit   <= 3'd0;
            RsTx     <= tx_shift[0];
          end
        end
        ST_DATA: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            if (tx_bit == 3'd7) begin
              tx_state <= ctrl[2] ? ST_PARITY : ST_STOP;
              RsTx     <= ctrl[2] ? tx_par : 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              RsTx     <= tx_shift[1];
            end
          end
        end
        ST_PARITY: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx_state <= ST_STOP;
            RsTx     <= 1'b1;
          end
        end
        default: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) tx_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The receiver counts ticks from the detected falling edge and acts when
  // the count reaches 7, i.e. on the 8th tick (mid-bit). State changes happen
  // there too, and the 4-bit counter keeps running, so the next sample falls
  // exactly 16 ticks later.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_state   <= ST_IDLE;
      rx_tick    <= 4'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'd0;
      rx_par_en  <= 1'b0;
      rx_par_ok  <= 1'b1;
      rx_push    <= 1'b0;
      rx_byte    <= 8'd0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      // Software clears come first so a hardware set later in this block
      // overrides a clear in the same cycle.
      if (wr_status) begin
        if (HWDATA[3]) overrun    <= 1'b0;
        if (HWDATA[4]) parity_err <= 1'b0;
        if (HWDATA[5]) frame_err  <= 1'b0;
      end
      if (rx_state == ST_IDLE) begin
        if (ctrl[1] && rx_prev && !rx_sync) begin
          rx_state  <= ST_START;
          rx_tick   <= 4'd0;
          rx_par_en <= ctrl[2];
          rx_par_ok <= 1'b1;
        end
      end else if (tick) begin
        rx_tick <= rx_tick + 4'd1;
        if (rx_tick == 4'd7) begin
          case (rx_state)
            ST_START: begin
              if (rx_sync) begin
                rx_state <= ST_IDLE;
              end else begin
                rx_state <= ST_DATA;
                rx_bit   <= 3'd0;
              end
            end
            ST_DATA: begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
              if (rx_bit == 3'd7) rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
              else                rx_bit   <= rx_bit + 3'd1;
            end
            ST_PARITY: begin
              rx_par_ok <= (rx_sync == ((^rx_shift) ^ ctrl[3]));
              rx_state  <= ST_STOP;
            end
            default: begin
              rx_state <= ST_IDLE;
              if (!rx_sync)                    frame_err  <= 1'b1;
              else if (rx_par_en && !rx_par_ok) parity_err <= 1'b1;
              else if (rx_full)                 overrun    <= 1'b1;
              else begin
                rx_push <= 1'b1;
                rx_byte <= rx_shift;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) uart_irq <= 1'b0;
    else          uart_irq <= (ctrl[4] & ~rx_empty) | (ctrl[5] & tx_empty) |
                              (ctrl[6] & (frame_err | parity_err | overrun));
  end

endmodule

// File: tb/tb_ahb_uart_prog.sv
// ---------------------------------------------------------------------------
// tb_ahb_uart_prog
//   Directed bench for ahb_uart_prog with default parameters (16-deep FIFOs).
//   BAUDDIV=3 gives a 4-cycle tick and a 64-cycle bit time. HREADY is looped
//   back from HREADYOUT as in a single-slave system; RsRx is either driven by
//   the bench or looped back from RsTx.
// ---------------------------------------------------------------------------
module tb_ahb_uart_prog;

  localparam int BIT_CYC = 64;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        rs_rx;
  logic        rs_tx;
  logic        uart_irq;
  logic        loopback;
  logic        rx_drive;

  int total  = 0;
  int passed = 0;

  assign hready = hreadyout;
  assign rs_rx  = loopback ? rs_tx : rx_drive;

  always #5 hclk = ~hclk;

  ahb_uart_prog dut (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRDATA    (hrdata),
    .RsRx      (rs_rx),
    .RsTx      (rs_tx),
    .uart_irq  (uart_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, output int stall);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    stall = 0;
    while (!hreadyout && stall < 2000) begin
      @(negedge hclk);
      stall++;
    end
    if (stall >= 2000) check("write_timeout", 32'(stall), 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    int s;
    ahb_write(addr, data, s);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00;
    data = hrdata;
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hresetn = 1'b0; loopback = 1'b0; rx_drive = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  // Reset, program a 4-cycle tick and CTRL, then wait past the first reload
  // of the reset-value divisor so every later bit is 64 cycles.
  task automatic setup(input logic [31:0] ctrl_val);
    do_reset();
    wr(32'hC, 32'd3);
    wr(32'h8, ctrl_val);
    repeat (200) @(negedge hclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    @(negedge hclk);
    rx_drive = 1'b0;
    repeat (BIT_CYC) @(negedge hclk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = d[i];
      repeat (BIT_CYC) @(negedge hclk);
    end
    if (use_par) begin
      rx_drive = par_bit;
      repeat (BIT_CYC) @(negedge hclk);
    end
    rx_drive = stop_bit;
    repeat (BIT_CYC) @(negedge hclk);
    rx_drive = 1'b1;
    repeat (BIT_CYC) @(negedge hclk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [8:0]  bits;
    logic [7:0]  b;
    int          n;
    int          stall;
    int          st_sum;

    hresetn = 1'b0; loopback = 1'b0; rx_drive = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;

    // ---------------- reset values ----------------
    repeat (3) @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hrdata",    hrdata,         32'd0);
    check("rst_rstx",      32'(rs_tx),     32'd1);
    check("rst_irq",       32'(uart_irq),  32'd0);
    hresetn = 1'b1;
    ahb_read(32'h4, rd); check("rst_status",  rd, 32'h03);
    ahb_read(32'h8, rd); check("rst_ctrl",    rd, 32'h00);
    ahb_read(32'hC, rd); check("rst_bauddiv", rd, 32'd162);
    ahb_read(32'h0, rd); check("empty_data_read", rd, 32'd0);

    // ---------------- 1: TX waveform of 0xA5 ----------------
    setup(32'h01);
    ahb_read(32'hC, rd); check("bauddiv_rb", rd, 32'd3);
    ahb_read(32'h8, rd); check("ctrl_rb",    rd, 32'h01);
    wr(32'h0, 32'hA5);
    n = 0;
    while (rs_tx && n < 1000) begin @(negedge hclk); n++; end
    check("tx_start_seen", 32'(rs_tx), 32'd0);
    n = 0;
    while (!rs_tx && n < 1000) begin @(negedge hclk); n++; end
    check("tx_start_width", 32'(n), 32'd64);
    repeat (BIT_CYC / 2 - 1) @(negedge hclk);
    for (int i = 0; i < 9; i++) begin
      bits[i] = rs_tx;
      if (i < 8) repeat (BIT_CYC) @(negedge hclk);
    end
    // data bits LSB first, stop bit in [8]
    check("tx_bits_a5", 32'(bits), 32'h1A5);

    // ---------------- 2: loopback with even parity ----------------
    setup(32'h17);
    loopback = 1'b1;
    repeat (4) @(negedge hclk);
    check("lb_irq_idle", 32'(uart_irq), 32'd0);
    wr(32'h0, 32'h3C);
    n = 0;
    while (!uart_irq && n < 3000) begin @(negedge hclk); n++; end
    check("lb_irq_set", 32'(uart_irq), 32'd1);
    ahb_read(32'h0, rd); check("lb_data",   rd, 32'h3C);
    // tx_empty is also set: the transmitted byte has left the TX FIFO
    ahb_read(32'h4, rd); check("lb_status", rd, 32'h03);
    repeat (2) @(negedge hclk);
    check("lb_irq_clear", 32'(uart_irq), 32'd0);

    // ---------------- 3: TX FIFO full stall ----------------
    setup(32'h00);
    st_sum = 0;
    for (int i = 0; i < 16; i++) begin
      ahb_write(32'h0, 32'(i + 8'h30), stall);
      st_sum += stall;
    end
    check("fill_no_stall", 32'(st_sum), 32'd0);
    ahb_read(32'h4, rd); check("full_tx_status", rd, 32'h01);
    repeat (300) @(negedge hclk);
    check("tx_disabled_idle", 32'(rs_tx), 32'd1);
    // CTRL write data phase overlaps the address phase of the 17th DATA write
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8;
    @(negedge hclk);
    hwdata = 32'h01; haddr = 32'h0;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hEE;
    check("stall_first_cycle", 32'(hreadyout), 32'd0);
    stall = 0;
    while (!hreadyout && stall < 100) begin @(negedge hclk); stall++; end
    check("stall_until_pop", 32'(stall >= 1 && stall <= 4), 32'd1);
    check("tx_running", 32'(rs_tx), 32'd0);
    // reset mid-frame: RsTx back to idle without waiting for a clock
    #2 hresetn = 1'b0;
    #1 check("rst_mid_tx", 32'(rs_tx), 32'd1);
    @(negedge hclk);
    hresetn = 1'b1;
    ahb_read(32'h4, rd); check("rst_fifo_lost", rd, 32'h03);

    // ---------------- 4: parity error, then valid even/odd frames ----------------
    setup(32'h06);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    ahb_read(32'h4, rd); check("par_err_status", rd, 32'h13);
    wr(32'h4, 32'h10);
    ahb_read(32'h4, rd); check("par_err_clear", rd, 32'h03);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    ahb_read(32'h0, rd); check("even_par_data", rd, 32'h3C);
    wr(32'h8, 32'h0E);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    ahb_read(32'h0, rd); check("odd_par_data", rd, 32'h81);

    // ---------------- 5: RX overrun and FIFO order ----------------
    setup(32'h02);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 37 + 5);
      send_frame(b, 1'b0, 1'b0, 1'b1);
    end
    ahb_read(32'h4, rd); check("ovr_status", rd, 32'h0E);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 5);
      ahb_read(32'h0, rd); check("rx_order", rd, {24'd0, b});
    end
    ahb_read(32'h4, rd); check("ovr_after_drain", rd, 32'h0B);
    wr(32'h8, 32'h42);
    repeat (2) @(negedge hclk);
    check("err_irq_set", 32'(uart_irq), 32'd1);
    wr(32'h4, 32'h08);
    repeat (2) @(negedge hclk);
    check("err_irq_clear", 32'(uart_irq), 32'd0);

    // ---------------- 6: short glitch and bad stop bit ----------------
    setup(32'h02);
    @(negedge hclk);
    rx_drive = 1'b0;
    repeat (8) @(negedge hclk);
    rx_drive = 1'b1;
    repeat (3 * BIT_CYC) @(negedge hclk);
    ahb_read(32'h4, rd); check("glitch_no_push", rd, 32'h03);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    ahb_read(32'h4, rd); check("frame_err_status", rd, 32'h23);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
